// File: rtl/board_key_debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module : board_key_debounce_pkg
// Brief  : Register address map for the board key debouncer.
// Rev    : 1.0
// ============================================================================
package board_key_debounce_pkg;

    localparam logic [1:0] ADDR_LEVEL   = 2'd0;
    localparam logic [1:0] ADDR_PRESS   = 2'd1;
    localparam logic [1:0] ADDR_RELEASE = 2'd2;
    localparam logic [1:0] ADDR_MASK    = 2'd3;

endpackage
`default_nettype wire

// File: rtl/board_key_debounce_if.sv
`default_nettype none
// ============================================================================
// Module : board_key_debounce_if
// Brief  : CPU I/O-space register bus (address, write strobe, data in/out).
// Rev    : 1.0
// ============================================================================
interface board_key_debounce_if #(
    parameter int DATA_WIDTH = 8
);
    logic [1:0]            addr;
    logic                  we;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] data;

    modport master (output addr, output we, output wdata, input  data);
    modport slave  (input  addr, input  we, input  wdata, output data);
endinterface
`default_nettype wire

// File: rtl/board_key_debounce_cell.sv
`default_nettype none
// ============================================================================
// Module : key_debounce_cell
// Brief  : Single-key debouncer: counter, accepted level and press/release pulses.
// Rev    : 1.0
// ============================================================================
module key_debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic sample,
    output logic      level,
    output logic      press,
    output logic      rel
);
    localparam logic [CNT_WIDTH-1:0] c_cnt_last = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_level;
    logic                 r_press;
    logic                 r_release;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (sample == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                // Last of DEBOUNCE_CYCLES consecutive differing samples.
                r_cnt     <= '0;
                r_level   <= sample;
                r_press   <= sample;
                r_release <= ~sample;
            end else begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign level = r_level;
    assign press = r_press;
    assign rel   = r_release;
endmodule
`default_nettype wire

// File: rtl/synchronizer.sv
`default_nettype none
// ============================================================================
// Module : synchronizer
// Brief  : Two-flop synchroniser for asynchronous inputs, per-bit.
// Rev    : 1.0
// ============================================================================
module synchronizer #(
    parameter int                    DATA_WIDTH  = 1,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic [DATA_WIDTH-1:0] din,
    output logic      [DATA_WIDTH-1:0] dout
);
    logic [DATA_WIDTH-1:0] r_meta;
    logic [DATA_WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_meta <= RESET_VALUE;
            r_sync <= RESET_VALUE;
        end else begin
            r_meta <= din;
            r_sync <= r_meta;
        end
    end

    assign dout = r_sync;
endmodule
`default_nettype wire

// File: rtl/board_key_debounce.sv
`default_nettype none
// ============================================================================
// Module : board_key_debounce
// Brief  : Debounced board keys with sticky event latches, mask and interrupt.
// Rev    : 1.0
// ============================================================================
module board_key_debounce
    import board_key_debounce_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int KEY_WIDTH       = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire logic [KEY_WIDTH-1:0] ext_board_key,
    board_key_debounce_if.slave       bus,
    output logic      [KEY_WIDTH-1:0] key_level,
    output logic      [KEY_WIDTH-1:0] key_press,
    output logic      [KEY_WIDTH-1:0] key_release,
    output logic                      irq
);
    logic [KEY_WIDTH-1:0]  w_sync;
    logic [KEY_WIDTH-1:0]  w_sample;
    logic [KEY_WIDTH-1:0]  w_wbits;
    logic [KEY_WIDTH-1:0]  w_press_clr;
    logic [KEY_WIDTH-1:0]  w_release_clr;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic [KEY_WIDTH-1:0]  r_press_latch;
    logic [KEY_WIDTH-1:0]  r_release_latch;
    logic [KEY_WIDTH-1:0]  r_mask;
    logic                  w_unused;

    // Synchroniser resets to "released" so a held key is seen as a fresh edge.
    synchronizer #(
        .DATA_WIDTH  (KEY_WIDTH),
        .RESET_VALUE ({KEY_WIDTH{1'b1}})
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (ext_board_key),
        .dout  (w_sync)
    );

    assign w_sample = ~w_sync;

    for (genvar i = 0; i < KEY_WIDTH; i++) begin : g_key
        key_debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_WIDTH       (CNT_WIDTH)
        ) u_cell (
            .clk    (clk),
            .reset  (reset),
            .sample (w_sample[i]),
            .level  (key_level[i]),
            .press  (key_press[i]),
            .rel    (key_release[i])
        );
    end

    assign w_wbits       = bus.wdata[KEY_WIDTH-1:0];
    assign w_press_clr   = (bus.we && bus.addr == ADDR_PRESS)   ? w_wbits : '0;
    assign w_release_clr = (bus.we && bus.addr == ADDR_RELEASE) ? w_wbits : '0;

    // Set is OR-ed in after the clear so a coincident pulse survives W1C.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_press_latch   <= '0;
            r_release_latch <= '0;
            r_mask          <= '0;
        end else begin
            r_press_latch   <= (r_press_latch & ~w_press_clr) | key_press;
            r_release_latch <= (r_release_latch & ~w_release_clr) | key_release;
            if (bus.we && bus.addr == ADDR_MASK) begin
                r_mask <= w_wbits;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (bus.addr)
            ADDR_LEVEL:   w_rdata[KEY_WIDTH-1:0] = key_level;
            ADDR_PRESS:   w_rdata[KEY_WIDTH-1:0] = r_press_latch;
            ADDR_RELEASE: w_rdata[KEY_WIDTH-1:0] = r_release_latch;
            ADDR_MASK:    w_rdata[KEY_WIDTH-1:0] = r_mask;
            default:      w_rdata = '0;
        endcase
    end

    assign bus.data = w_rdata;
    assign irq      = |(r_press_latch & r_mask);
    assign w_unused = &{1'b0, bus.wdata};
endmodule
`default_nettype wire
